// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - command codes, sequencer state type and operand addresses for sys_ctrl_rx
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } sys_state_e;

  // States that are waiting on the next frame byte from the UART.
  function automatic logic is_byte_wait(input sys_state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_FUN);
  endfunction

endpackage

// File: rtl/sys_ctrl_frame_timer.sv
// rtl/sys_ctrl_frame_timer.sv - loadable down-counter that pulses expire after TIMEOUT_CYC running cycles
// Instantiated by sys_ctrl_rx only when SYS_CTRL_RX_TIMEOUT_EN is defined.
module sys_ctrl_frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] START = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = START;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= START;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A fresh byte (load) always beats an expiry in the same cycle.
  assign expire = run && !load && (cnt_q == '0);

endmodule

// File: rtl/sys_ctrl_rx.sv
// rtl/sys_ctrl_rx.sv - UART command frame sequencer driving register file, ALU and TX FIFO
// Optional inter-byte timeout enabled by defining SYS_CTRL_RX_TIMEOUT_EN.
module sys_ctrl_rx
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     RX_P_DATA,
  input  logic                 RX_D_VLD,
  input  logic [WIDTH-1:0]     RF_RD_DATA,
  input  logic                 RF_RD_VLD,
  input  logic [2*WIDTH-1:0]   ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  input  logic                 FIFO_FULL,
  output logic [ADDR_W-1:0]    RF_ADDR,
  output logic                 RF_WR_EN,
  output logic                 RF_RD_EN,
  output logic [WIDTH-1:0]     RF_WR_DATA,
  output logic                 ALU_EN,
  output logic [3:0]           ALU_FUN,
  output logic                 CLK_GATE_EN,
  output logic [WIDTH-1:0]     TX_WR_DATA,
  output logic                 TX_WR_EN,
  output logic                 BUSY
);

  sys_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               is_alu_q, is_alu_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic               rf_wr_en_q, rf_wr_en_d;
  logic               rf_rd_en_q, rf_rd_en_d;
  logic [WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic               alu_en_q, alu_en_d;
  logic [3:0]         alu_fun_q, alu_fun_d;
  logic               clk_gate_en_q, clk_gate_en_d;
  logic               tmo_expire;
  logic               in_tx;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
  logic tmo_run;
  assign tmo_run = is_byte_wait(state_q);

  sys_ctrl_frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timer (
    .clk    (CLK),
    .resetn (RST),
    .load   (RX_D_VLD || !tmo_run),
    .run    (tmo_run),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    res_d        = res_q;
    is_alu_d     = is_alu_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(CMD_WR))           state_d = ST_WR_ADDR;
          else if (RX_P_DATA == WIDTH'(CMD_RD))      state_d = ST_RD_ADDR;
          else if (RX_P_DATA == WIDTH'(CMD_ALU_OP))  state_d = ST_ALU_A;
          else if (RX_P_DATA == WIDTH'(CMD_ALU_NOP)) state_d = ST_ALU_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = RX_P_DATA;
          state_d      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_rd_en_d = 1'b1;
          addr_d     = RX_P_DATA[ADDR_W-1:0];
          rf_addr_d  = RX_P_DATA[ADDR_W-1:0];
          is_alu_d   = 1'b0;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RF_RD_VLD) begin
          res_d   = {{WIDTH{1'b0}}, RF_RD_DATA};
          state_d = ST_TX_LO;
        end
      end
      ST_ALU_A: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_W'(OPA_ADDR);
          rf_wr_data_d = RX_P_DATA;
          state_d      = ST_ALU_B;
        end
      end
      ST_ALU_B: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_W'(OPB_ADDR);
          rf_wr_data_d = RX_P_DATA;
          state_d      = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          is_alu_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_d   = ALU_OUT;
          state_d = ST_TX_LO;
        end
      end
      // Push retries every cycle until the FIFO has room.
      ST_TX_LO: begin
        if (!FIFO_FULL) state_d = is_alu_q ? ST_TX_HI : ST_IDLE;
      end
      ST_TX_HI: begin
        if (!FIFO_FULL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_expire) begin
      state_d = ST_IDLE;
    end

    clk_gate_en_d = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      res_q         <= '0;
      is_alu_q      <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      res_q         <= res_d;
      is_alu_q      <= is_alu_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
    end
  end

  // The push strobe looks at FIFO_FULL in the same cycle so a push can never land on a full FIFO.
  assign in_tx      = (state_q == ST_TX_LO) || (state_q == ST_TX_HI);
  assign TX_WR_EN   = in_tx && !FIFO_FULL;
  assign TX_WR_DATA = !TX_WR_EN ? '0 :
                      (state_q == ST_TX_HI) ? res_q[2*WIDTH-1:WIDTH] : res_q[WIDTH-1:0];

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// tb/tb_sys_ctrl_rx.sv - randomized frame-level bench for sys_ctrl_rx against an event-queue reference model
module tb_sys_ctrl_rx;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [7:0]        RX_P_DATA = '0;
  logic              RX_D_VLD = 1'b0;
  logic [7:0]        RF_RD_DATA = '0;
  logic              RF_RD_VLD = 1'b0;
  logic [15:0]       ALU_OUT = '0;
  logic              ALU_OUT_VLD = 1'b0;
  logic              FIFO_FULL = 1'b0;
  logic [3:0]        RF_ADDR;
  logic              RF_WR_EN;
  logic              RF_RD_EN;
  logic [7:0]        RF_WR_DATA;
  logic              ALU_EN;
  logic [3:0]        ALU_FUN;
  logic              CLK_GATE_EN;
  logic [7:0]        TX_WR_DATA;
  logic              TX_WR_EN;
  logic              BUSY;

  sys_ctrl_rx #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .RF_ADDR(RF_ADDR),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_WR_DATA(RF_WR_DATA),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_WR_DATA(TX_WR_DATA), .TX_WR_EN(TX_WR_EN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int bad_push = 0;
  int gate_bad = 0;
  int gate_seen = 0;
  int unsigned obs_wr[$], obs_rd[$], obs_alu[$], obs_tx[$];
  int unsigned exp_wr[$], exp_rd[$], exp_alu[$], exp_tx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (RF_WR_EN) obs_wr.push_back(32'({RF_ADDR, RF_WR_DATA}));
      if (RF_RD_EN) obs_rd.push_back(32'(RF_ADDR));
      if (ALU_EN)   obs_alu.push_back(32'(ALU_FUN));
      if (TX_WR_EN) obs_tx.push_back(32'(TX_WR_DATA));
      if (TX_WR_EN && FIFO_FULL) bad_push++;
      if (CLK_GATE_EN && (!BUSY || TX_WR_EN)) gate_bad++;
      if (ALU_EN && !CLK_GATE_EN) gate_bad++;
      if (CLK_GATE_EN) gate_seen++;
    end
  end

  function automatic logic [31:0] all_outs();
    return 32'({RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_WR_DATA, TX_WR_EN, BUSY});
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Reference model: the RF/ALU/TX events a complete frame must produce.
  task automatic model(input int kind, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [15:0] res);
    int unsigned u1, u2, u3, ur;
    u1 = b1; u2 = b2; u3 = b3; ur = res;
    case (kind)
      0: exp_wr.push_back((u1 % 16) * 256 + u2);
      1: begin exp_rd.push_back(u1 % 16); exp_tx.push_back(ur % 256); end
      2: begin
        exp_wr.push_back(0 * 256 + u1);
        exp_wr.push_back(1 * 256 + u2);
        exp_alu.push_back(u3 % 16);
        exp_tx.push_back(ur % 256);
        exp_tx.push_back(ur / 256);
      end
      3: begin
        exp_alu.push_back(u3 % 16);
        exp_tx.push_back(ur % 256);
        exp_tx.push_back(ur / 256);
      end
      default: ;
    endcase
  endtask

  task automatic drain(input string tag);
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
    check({tag, "_nrd"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) check({tag, "_rd"}, obs_rd[i], exp_rd[i]);
    check({tag, "_nalu"}, obs_alu.size(), exp_alu.size());
    for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++) check({tag, "_alu"}, obs_alu[i], exp_alu[i]);
    check({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) check({tag, "_tx"}, obs_tx[i], exp_tx[i]);
    obs_wr.delete(); obs_rd.delete(); obs_alu.delete(); obs_tx.delete();
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
  endtask

  task automatic wait_idle(input string tag, input int full_pct);
    int n = 0;
    while (BUSY && n < 200) begin
      FIFO_FULL = ($urandom_range(0, 99) < full_pct);
      tick();
      n++;
    end
    FIFO_FULL = 1'b0;
    check({tag, "_idle"}, BUSY, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int kind, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [15:0] res, input int full_pct, input bit stray);
    gate_seen = 0;
    model(kind, b1, b2, b3, res);
    case (kind)
      0: begin send(8'hAA); send(b1); send(b2); end
      1: begin
        send(8'hBB); send(b1);
        repeat ($urandom_range(0, 3)) tick();
        if (stray) begin RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1; end
        RF_RD_DATA = res[7:0];
        RF_RD_VLD  = 1'b1;
        tick();
        RF_RD_VLD  = 1'b0;
        RX_D_VLD   = 1'b0;
      end
      2, 3: begin
        if (kind == 2) begin send(8'hCC); send(b1); send(b2); end
        else send(8'hDD);
        send(b3);
        if (stray) pulse(8'hBB);
        repeat ($urandom_range(0, 3)) tick();
        ALU_OUT     = res;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
      end
      default: send(b1);
    endcase
    wait_idle(tag, full_pct);
    repeat (2) tick();
    drain(tag);
    check({tag, "_gate"}, 32'(gate_seen > 0), 32'(kind == 2 || kind == 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kind;
    logic [7:0] b1, b2, b3;
    logic [15:0] res;

    repeat (3) tick();
    check("reset_outs", all_outs(), 32'h0);
    RST = 1'b1;
    tick();

    // Write with exact strobe latency.
    exp_wr.push_back(5 * 256 + 8'h3C);
    send(8'hAA); send(8'h05); pulse(8'h3C);
    check("wr_latency", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h5, 8'h3C});
    repeat (3) tick();
    drain("dir_wr");

    run_frame("dir_rd", 1, 8'h05, 8'h00, 8'h00, 16'h003C, 0, 1'b0);
    run_frame("dir_aluop", 2, 8'h10, 8'h20, 8'h02, 16'h0200, 0, 1'b0);

    // Backpressure on an ALU-without-operands frame.
    model(3, 8'h00, 8'h00, 8'h01, 16'hABCD);
    send(8'hDD); pulse(8'h01);
    check("alu_latency", {ALU_EN, ALU_FUN, CLK_GATE_EN}, {1'b1, 4'h1, 1'b1});
    FIFO_FULL   = 1'b1;
    ALU_OUT     = 16'hABCD;
    ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    repeat (5) tick();
    check("bp_no_push", obs_tx.size(), 0);
    wait_idle("bp", 0);
    repeat (2) tick();
    drain("bp");

    // Garbage first byte, then reset mid-frame.
    pulse(8'h55);
    check("garbage_busy", BUSY, 1'b0);
    send(8'hAA); send(8'h03);
    RST = 1'b0;
    tick();
    check("midframe_rst_outs", all_outs(), 32'h0);
    RST = 1'b1;
    send(8'h77);
    repeat (3) tick();
    check("post_rst_busy", BUSY, 1'b0);
    drain("rst");

    // Reset while a read result is stuck behind a full FIFO.
    exp_rd.push_back(2);
    send(8'hBB); send(8'h02);
    FIFO_FULL = 1'b1; RF_RD_DATA = 8'h99; RF_RD_VLD = 1'b1;
    tick();
    RF_RD_VLD = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("push_rst_outs", all_outs(), 32'h0);
    RST = 1'b1; FIFO_FULL = 1'b0;
    repeat (4) tick();
    drain("push_rst");

`ifdef SYS_CTRL_RX_TIMEOUT_EN
    pulse(8'hAA);
    repeat (20) tick();
    check("tmo_busy", BUSY, 1'b0);
    pulse(8'h09);
    repeat (4) tick();
    check("tmo_busy_after", BUSY, 1'b0);
    drain("tmo");
`else
    exp_wr.push_back(9 * 256 + 8'h44);
    pulse(8'hAA);
    repeat (20) tick();
    check("notmo_busy", BUSY, 1'b1);
    pulse(8'h09); pulse(8'h44);
    repeat (3) tick();
    drain("notmo");
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      b1   = 8'($urandom);
      b2   = 8'($urandom);
      b3   = 8'($urandom);
      res  = 16'($urandom);
      if (kind == 4) begin
        while (b1 == 8'hAA || b1 == 8'hBB || b1 == 8'hCC || b1 == 8'hDD) b1 = 8'($urandom);
      end
      run_frame($sformatf("rnd%0d", i), kind, b1, b2, b3, res,
                $urandom_range(0, 60), ($urandom_range(0, 3) == 0));
    end

    check("never_push_full", bad_push, 0);
    check("gate_rules", gate_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
